tapdelay_sequencer: RTL

- Owns a circular tap-delay history of the last NUM_TAPS input samples.
- On each accepted sample, streams the full history newest-to-oldest into the shared MAC datapath with a coefficient index per beat.
- Waits for the MAC's completion pulse before accepting the next sample.
- Sits between the sample source and the NARX neuron MAC, replacing free-running tap counters with a handshaked scheduler.

---
 rtl/tapdelay_pkg.sv | 26 ++
 rtl/tap_ptr_counter.sv | 48 ++++
 rtl/tapdelay_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tapdelay_pkg.sv
// Shared types and constants for the tap-delay sequencer and its pointer counters.
package tapdelay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_TAPS = 17;
    localparam int DEFAULT_DATA_W   = 16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Smallest pointer width able to address num_taps history slots.
    function automatic int calc_idx_w(input int num_taps);
        int w;
        w = 1;
        while ((1 << w) < num_taps) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tap_ptr_counter.sv
// Modulo-MODULUS pointer with a synchronous load and an up/down step.
// The wrap is an explicit compare so MODULUS need not be a power of two.
module tap_ptr_counter
    import tapdelay_pkg::*;
#(
    parameter int MODULUS = DEFAULT_NUM_TAPS,
    parameter int W       = calc_idx_w(DEFAULT_NUM_TAPS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next pointer value: load wins over a step; steps wrap at both ends.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                count_d = (count_q == MAX_VAL) ? '0 : count_q + W'(1);
            end else begin
                count_d = (count_q == '0) ? MAX_VAL : count_q - W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tapdelay_sequencer.sv
// Tap-delay history plus handshaked scheduler feeding the shared MAC.
// Each accepted sample triggers one newest-to-oldest sweep of the history,
// then the block waits for the MAC completion pulse before taking more input.
module tapdelay_sequencer
    import tapdelay_pkg::*;
#(
    parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int IDX_W    = calc_idx_w(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [DATA_W-1:0] mac_data,
    output logic [IDX_W-1:0]  mac_coef_idx,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              mac_done,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;

    logic [DATA_W-1:0] hist_q [NUM_TAPS];
    logic [DATA_W-1:0] hist_d [NUM_TAPS];

    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_ptr;

    logic accept;
    logic do_flush;
    logic beat_xfer;
    logic last_beat;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign do_flush  = (state_q == IDLE) && flush;
    assign beat_xfer = (state_q == ISSUE) && mac_ready;
    assign last_beat = (idx_q == LAST_IDX);

    // Write pointer: steps on each accepted sample, returns to slot 0 on flush.
    tap_ptr_counter #(
        .MODULUS (NUM_TAPS),
        .W       (IDX_W)
    ) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (do_flush),
        .load_val ('0),
        .en       (accept),
        .dir      (DIR_UP),
        .count    (wr_ptr)
    );

    // Read pointer: starts at the slot just written, walks back toward older samples.
    tap_ptr_counter #(
        .MODULUS (NUM_TAPS),
        .W       (IDX_W)
    ) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (wr_ptr),
        .en       (beat_xfer),
        .dir      (DIR_DOWN),
        .count    (rd_ptr)
    );

    // History update: flush clears every slot at once, otherwise store the accepted sample.
    always_comb begin
        hist_d = hist_q;
        if (do_flush) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_d[i] = '0;
            end
        end else if (accept) begin
            hist_d[wr_ptr] = in_data;
        end
    end

    // History register array; kept in flops so the flush is single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    // Next state and beat index; mac_done only matters while waiting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (beat_xfer) begin
                    if (last_beat) begin
                        state_d = WAIT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT: begin
                if (mac_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and beat index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // MAC-side outputs decode only registered state; they are zero outside ISSUE.
    always_comb begin
        mac_valid    = 1'b0;
        mac_data     = '0;
        mac_coef_idx = '0;
        mac_first    = 1'b0;
        mac_last     = 1'b0;
        if (state_q == ISSUE) begin
            mac_valid    = 1'b1;
            mac_data     = hist_q[rd_ptr];
            mac_coef_idx = idx_q;
            mac_first    = (idx_q == '0);
            mac_last     = last_beat;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
